// File: rtl/transfer_pkg.sv
// transfer_pkg: sizes and address types shared by the transfer controller and datapath
package transfer_pkg;
   localparam int DATA_W_DEF  = 8;
   localparam int DEPTH_A_DEF = 8;
   localparam int DEPTH_B_DEF = 4;
   localparam int AW_A_DEF    = $clog2(DEPTH_A_DEF);
   localparam int AW_B_DEF    = $clog2(DEPTH_B_DEF);
   typedef logic [AW_A_DEF-1:0] addr_a_t;
   typedef logic [AW_B_DEF-1:0] addr_b_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MOD up counter with synchronous active-low clear and increment enable
module wrap_counter #(
   parameter int W   = 3,
   parameter int MOD = 8
) (
   input  logic         clock,
   input  logic         clear_n,
   input  logic         inc,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] LAST = W'(MOD - 1);
   always_ff @(posedge clock)
      if (!clear_n) count <= '0;
      else if (inc) count <= (count == LAST) ? '0 : count + 1'b1;
endmodule

// File: rtl/transfer_datapath.sv
// transfer_datapath: strobe-driven store of input words into memory A and pair sums into memory B
module transfer_datapath
   import transfer_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH_A = DEPTH_A_DEF,
   parameter int DEPTH_B = DEPTH_B_DEF,
   localparam int AW_A   = $clog2(DEPTH_A),
   localparam int AW_B   = $clog2(DEPTH_B)
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              WEA,
   input  logic              IncA,
   input  logic              WEB,
   input  logic              IncB,
   input  logic [DATA_W-1:0] DataIn,
   input  logic [AW_B-1:0]   RdAddrB,
   output logic [AW_A-1:0]   AddrA,
   output logic [AW_B-1:0]   AddrB,
   output logic [DATA_W-1:0] DataA,
   output logic [DATA_W-1:0] PrevA,
   output logic [DATA_W:0]   RdDataB,
   output logic              Done
);
   logic [DATA_W-1:0] mem_a [DEPTH_A];
   logic [DATA_W:0]   mem_b [DEPTH_B];

   wrap_counter #(.W(AW_A), .MOD(DEPTH_A)) u_addr_a (
      .clock(clock), .clear_n(Reset), .inc(IncA), .count(AddrA)
   );
   wrap_counter #(.W(AW_B), .MOD(DEPTH_B)) u_addr_b (
      .clock(clock), .clear_n(Reset), .inc(IncB), .count(AddrB)
   );

   assign DataA = mem_a[AddrA];

   // All reads below see pre-edge contents, so simultaneous strobes compose without ordering hazards
   always_ff @(posedge clock) begin
      if (!Reset) begin
         mem_a   <= '{default: '0};
         mem_b   <= '{default: '0};
         PrevA   <= '0;
         RdDataB <= '0;
         Done    <= 1'b0;
      end else begin
         if (WEA) mem_a[AddrA] <= DataIn;
         if (IncA && !WEA) PrevA <= DataA;
         if (WEB) mem_b[AddrB] <= {1'b0, PrevA} + {1'b0, DataA};
         RdDataB <= mem_b[RdAddrB];
         if (IncB && AddrB == AW_B'(DEPTH_B - 1)) Done <= 1'b1;
      end
   end
endmodule

// File: doc/transfer_datapath.md
Name: transfer_datapath

Overview:
- Datapath stage directly downstream of the transfer controller.
- Consumes the controller's WEA/IncA/WEB/IncB strobes. Stores incoming words into memory A, then pairs consecutive A words and writes their sum into memory B.
- Provides a registered readback port on memory B so the testbench and host can inspect the results.

Parameters:
- DATA_W, 8, width of input words and memory A entries
- DEPTH_A, 8, memory A depth (power of two)
- DEPTH_B, 4, memory B depth (power of two)
- AW_A/AW_B are derived: clog2(DEPTH_A), clog2(DEPTH_B); they are not overridable.

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clock)
- WEA  in  1  write DataIn into memory A at AddrA
- IncA  in  1  advance AddrA
- WEB  in  1  write pair sum into memory B at AddrB
- IncB  in  1  advance AddrB
- DataIn  in  DATA_W  word to store in memory A
- RdAddrB  in  AW_B  readback address for memory B
- AddrA  out  AW_A  current memory A address (registered)
- AddrB  out  AW_B  current memory B address (registered)
- DataA  out  DATA_W  combinational read of memA[AddrA]
- PrevA  out  DATA_W  pair-holding register
- RdDataB  out  DATA_W+1  registered memB[RdAddrB]
- Done  out  1  sticky flag: memory B has been filled once

Behaviour:
- Reset (Reset==0 at posedge):
  - AddrA, AddrB, PrevA, RdDataB and Done all become 0.
  - All memA and memB entries are cleared to 0.
  - Reset overrides every strobe in the same cycle. Reset mid-transfer abandons the transfer; nothing is retained.
- Memory A:
  - If WEA=1: memA[AddrA] <= DataIn, using the pre-increment AddrA.
  - If IncA=1: AddrA <= AddrA+1, wrapping DEPTH_A-1 -> 0.
  - WEA without IncA rewrites the same location.
  - IncA without WEA is a read step.
- PrevA:
  - If IncA=1 and WEA=0: PrevA <= memA[AddrA], i.e. the word being stepped past.
  - Otherwise PrevA holds its value.
- Memory B:
  - If WEB=1: memB[AddrB] <= {1'b0,PrevA} + {1'b0,memA[AddrA]}.
  - The sum is DATA_W+1 bits, so it never overflows.
  - Both memA[AddrA] and PrevA are the values before the current edge.
  - If IncB=1: AddrB <= AddrB+1, wrapping DEPTH_B-1 -> 0.
- Done:
  - Set when IncB=1 and AddrB==DEPTH_B-1.
  - Cleared only by reset.
- Simultaneous strobes:
  - WEA and WEB in the same cycle: WEB reads the old memA content (read-before-write).
  - IncA and WEB in the same cycle: WEB uses the pre-increment AddrA and the old PrevA.
  - All four strobes are legal in any combination; no strobe is ignored.
- Readback:
  - RdDataB <= memB[RdAddrB] every cycle (1-cycle latency).
  - Reads the old value if that location is written in the same cycle.
- No internal FSM. Sequencing is owned by the controller; this block is purely strobe-driven.

Decomposition:
- Shared package transfer_pkg holds:
  - DATA_W, DEPTH_A and DEPTH_B defaults, shared with the controller
  - the addr_a_t and addr_b_t typedefs
- One natural sub-module: wrap_counter (parameterised width/modulus, sync active-low clear, increment enable). Instantiate it twice, for AddrA and AddrB.
- The memories are inline register arrays.

Test Plan:
- Reset: drive Reset=0 for 2 cycles with all strobes=1.
  - Required: AddrA=0, AddrB=0, PrevA=0, Done=0, and RdDataB=0 for every RdAddrB.
- Fill A: WEA=IncA=1 for 8 cycles with DataIn=10,20,...,80.
  - Required: AddrA returns to 0, and a direct read of memA gives 10..80 at addresses 0..7.
- Pair/sum step: after the fill, apply IncA (WEA=0) for one cycle -> PrevA=10 and AddrA=1. Then apply WEB+IncA.
  - Required: memB[0]=30, PrevA=20, AddrA=2.
- Full transfer: repeat the pair/sum step with IncB on each following cycle, 4 pairs in total.
  - Required: memB = 30,70,110,150; Done rises on the 4th IncB; AddrB=0.
- Width/boundary: A words 255 and 255 paired.
  - Required: memB entry = 510 (9 bits). Also, AddrA wraps 7 -> 0 on IncA.
- Reset mid-operation: assert Reset=0 after 2 B writes.
  - Required: everything returns to 0 and Done=0. A subsequent full transfer repeats the exact same results.
